// File: rtl/wfc_pkg.sv
// Shared types for the wall-following controller: FSM state codes and turn direction.
package wfc_pkg;

  typedef enum logic [2:0] {
    ST_STANDBY = 3'd0,
    ST_SEEK    = 3'd1,
    ST_FOLLOW  = 3'd2,
    ST_TURN_R  = 3'd3,
    ST_TURN_L  = 3'd4,
    ST_REMOVE  = 3'd5
  } state_t;

  localparam logic SENT_RIGHT = 1'b0;
  localparam logic SENT_LEFT  = 1'b1;

endpackage

// File: rtl/sensor_debounce.sv
// Per-sensor debounce: the filtered bit follows raw only after CYCLES consecutive
// disagreeing edges; any agreeing edge restarts the count.
module sensor_debounce #(
  parameter int unsigned CYCLES = 3
) (
  input  logic clockc2,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int unsigned CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clockc2) begin
    if (!reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (raw == filt) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      filt <= raw;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wall_follow_ctrl.sv
// Wall-following controller for the pipe-cleaning robot; registered Moore outputs.
// Define WFC_DEBOUNCE_EN to debounce the sensors, otherwise each is a single flop.
module wall_follow_ctrl
  import wfc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned TURN_CYCLES     = 4,
  parameter int unsigned LOST_CYCLES     = 5,
  parameter int unsigned REMOVE_MAX      = 8,
  parameter int unsigned MAX_TURNS       = 3
) (
  input  logic       clockc2,
  input  logic       reset,
  input  logic       start,
  input  logic       head,
  input  logic       left,
  input  logic       under,
  input  logic       barreira,
  output logic       avancar,
  output logic       girar,
  output logic       sentido,
  output logic       remover,
  output logic       fault,
  output logic [2:0] state_o
);

  if (DEBOUNCE_CYCLES < 1 || TURN_CYCLES < 1 || LOST_CYCLES < 1 ||
      REMOVE_MAX < 1 || MAX_TURNS < 1) begin : g_param_check
    $error("wall_follow_ctrl: all cycle/count parameters must be >= 1");
  end

  localparam int unsigned TW = $clog2(TURN_CYCLES + 1);
  localparam int unsigned LW = $clog2(LOST_CYCLES + 1);
  localparam int unsigned RW = $clog2(REMOVE_MAX + 1);
  localparam int unsigned NW = $clog2(MAX_TURNS + 1);

  localparam logic [TW-1:0] TURN_LOAD   = TW'(TURN_CYCLES);
  localparam logic [TW-1:0] TURN_EXPIRE = TW'(1);
  localparam logic [LW-1:0] LOST_LAST   = LW'(LOST_CYCLES - 1);
  localparam logic [RW-1:0] REM_LAST    = RW'(REMOVE_MAX - 1);
  localparam logic [NW-1:0] RETRY_LAST  = NW'(MAX_TURNS - 1);

  logic h, l, u, b;

`ifdef WFC_DEBOUNCE_EN
  sensor_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_head (
    .clockc2(clockc2), .reset(reset), .raw(head),     .filt(h));
  sensor_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clockc2(clockc2), .reset(reset), .raw(left),     .filt(l));
  sensor_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_under (
    .clockc2(clockc2), .reset(reset), .raw(under),    .filt(u));
  sensor_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_barreira (
    .clockc2(clockc2), .reset(reset), .raw(barreira), .filt(b));
`else
  always_ff @(posedge clockc2) begin
    if (!reset) {h, l, u, b} <= '0;
    else        {h, l, u, b} <= {head, left, under, barreira};
  end
`endif

  state_t        state, state_n;
  logic [TW-1:0] turn_t, turn_n;
  logic [LW-1:0] lost, lost_n;
  logic [RW-1:0] rem, rem_n;
  logic [NW-1:0] retry, retry_n;
  logic          fault_n;
  logic          avancar_n, girar_n, sentido_n, remover_n;

  // Counters default to zero so that leaving a state always clears its counter.
  always_comb begin
    state_n = state;
    fault_n = fault;
    turn_n  = '0;
    lost_n  = '0;
    rem_n   = '0;
    retry_n = '0;

    unique case (state)
      ST_STANDBY: begin
        if (start && !u) begin
          state_n = ST_SEEK;
          fault_n = 1'b0;
        end
      end
      ST_SEEK, ST_FOLLOW: begin
        if (u) begin
          state_n = ST_STANDBY;
          fault_n = 1'b1;
        end else if (b) begin
          state_n = ST_REMOVE;
        end else if (h) begin
          state_n = ST_TURN_R;
          turn_n  = TURN_LOAD;
        end else if (state == ST_SEEK) begin
          if (l) state_n = ST_FOLLOW;
        end else if (!l) begin
          if (lost == LOST_LAST) begin
            state_n = ST_TURN_L;
            turn_n  = TURN_LOAD;
          end else begin
            lost_n = lost + 1'b1;
          end
        end
      end
      ST_TURN_R: begin
        retry_n = retry;
        if (u) begin
          state_n = ST_STANDBY;
          fault_n = 1'b1;
          retry_n = '0;
        end else if (turn_t <= TURN_EXPIRE) begin
          if (!h) begin
            state_n = ST_FOLLOW;
            retry_n = '0;
          end else if (retry == RETRY_LAST) begin
            state_n = ST_STANDBY;
            fault_n = 1'b1;
            retry_n = '0;
          end else begin
            retry_n = retry + 1'b1;
            turn_n  = TURN_LOAD;
          end
        end else begin
          turn_n = turn_t - 1'b1;
        end
      end
      ST_TURN_L: begin
        if (u) begin
          state_n = ST_STANDBY;
          fault_n = 1'b1;
        end else if (turn_t <= TURN_EXPIRE) begin
          state_n = l ? ST_FOLLOW : ST_SEEK;
        end else begin
          turn_n = turn_t - 1'b1;
        end
      end
      ST_REMOVE: begin
        if (u) begin
          state_n = ST_STANDBY;
          fault_n = 1'b1;
        end else if (!b) begin
          state_n = ST_FOLLOW;
        end else if (rem == REM_LAST) begin
          state_n = ST_STANDBY;
          fault_n = 1'b1;
        end else begin
          rem_n = rem + 1'b1;
        end
      end
      default: state_n = ST_STANDBY;
    endcase

    avancar_n = (state_n == ST_SEEK) || (state_n == ST_FOLLOW);
    girar_n   = (state_n == ST_TURN_R) || (state_n == ST_TURN_L);
    sentido_n = (state_n == ST_TURN_L) ? SENT_LEFT : SENT_RIGHT;
    remover_n = (state_n == ST_REMOVE);
  end

  always_ff @(posedge clockc2) begin
    if (!reset) begin
      state   <= ST_STANDBY;
      turn_t  <= '0;
      lost    <= '0;
      rem     <= '0;
      retry   <= '0;
      fault   <= 1'b0;
      avancar <= 1'b0;
      girar   <= 1'b0;
      sentido <= 1'b0;
      remover <= 1'b0;
      state_o <= '0;
    end else begin
      state   <= state_n;
      turn_t  <= turn_n;
      lost    <= lost_n;
      rem     <= rem_n;
      retry   <= retry_n;
      fault   <= fault_n;
      avancar <= avancar_n;
      girar   <= girar_n;
      sentido <= sentido_n;
      remover <= remover_n;
      state_o <= state_n;
    end
  end

endmodule

// File: tb/tb_wall_follow_ctrl.sv
// Directed, table-driven bench for wall_follow_ctrl (default parameters).
module tb_wall_follow_ctrl;

`ifdef WFC_DEBOUNCE_EN
  localparam int unsigned D = 3;
`else
  localparam int unsigned D = 1;
`endif

  localparam logic [2:0] S_STBY = 3'd0, S_SEEK = 3'd1, S_FOL = 3'd2,
                         S_TR = 3'd3, S_TL = 3'd4, S_REM = 3'd5;
  // {avancar, girar, sentido, remover, fault}
  localparam logic [4:0] O_NONE = 5'b00000, O_FLT = 5'b00001, O_FWD = 5'b10000,
                         O_TR = 5'b01000, O_TL = 5'b01100, O_REM = 5'b00010;

  logic clockc2 = 1'b0;
  logic reset, start, head, left, under, barreira;
  logic avancar, girar, sentido, remover, fault;
  logic [2:0] state_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          mon_en = 1'b0;

  wall_follow_ctrl dut (
    .clockc2(clockc2), .reset(reset), .start(start), .head(head), .left(left),
    .under(under), .barreira(barreira), .avancar(avancar), .girar(girar),
    .sentido(sentido), .remover(remover), .fault(fault), .state_o(state_o)
  );

  always #5 clockc2 = ~clockc2;

  typedef struct {
    string       name;
    logic        rst, st, hd, lf, un, ba;
    int unsigned edges;
    logic [2:0]  exp_state;
    logic [4:0]  exp_outs;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic r, logic s, logic h, logic l, logic u,
                              logic b, int unsigned e, logic [2:0] es, logic [4:0] eo);
    vec_t v;
    v.name = n; v.rst = r; v.st = s; v.hd = h; v.lf = l; v.un = u; v.ba = b;
    v.edges = e; v.exp_state = es; v.exp_outs = eo;
    vecs.push_back(v);
  endfunction

  task automatic tick(int unsigned n);
    repeat (n) begin
      @(posedge clockc2);
      @(negedge clockc2);
    end
  endtask

  task automatic check(string n, logic [2:0] es, logic [4:0] eo);
    logic [4:0] o;
    o = {avancar, girar, sentido, remover, fault};
    n_cmp++;
    if (state_o !== es) begin
      n_bad++;
      $display("FAIL %s state: got %0d expected %0d", n, state_o, es);
    end
    n_cmp++;
    if (o !== eo) begin
      n_bad++;
      $display("FAIL %s outputs{av,gi,se,re,fa}: got %b expected %b", n, o, eo);
    end
  endtask

  // Output exclusivity on every cycle.
  always @(negedge clockc2) begin
    if (mon_en) begin
      n_cmp++;
      if (int'(avancar) + int'(girar) + int'(remover) > 1 || (sentido && !girar)) begin
        n_bad++;
        $display("FAIL onehot: got av=%b gi=%b se=%b re=%b expected at most one active",
                 avancar, girar, sentido, remover);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //   name            rst st hd lf un ba edges    state   outputs
    add("reset",          0, 0, 0, 0, 0, 0, 2,       S_STBY, O_NONE);
    add("start_seek",     1, 1, 0, 0, 0, 0, 1,       S_SEEK, O_FWD);
    add("left_lat_pre",   1, 0, 0, 1, 0, 0, D,       S_SEEK, O_FWD);
    add("left_follow",    1, 0, 0, 1, 0, 0, 1,       S_FOL,  O_FWD);
    add("head_lat_pre",   1, 0, 1, 1, 0, 0, D,       S_FOL,  O_FWD);
    add("turn_r_enter",   1, 0, 1, 1, 0, 0, 1,       S_TR,   O_TR);
    add("turn_r_a1_end",  1, 0, 1, 1, 0, 0, 3,       S_TR,   O_TR);
    add("turn_r_retry1",  1, 0, 1, 1, 0, 0, 1,       S_TR,   O_TR);
    add("turn_r_a2_end",  1, 0, 1, 1, 0, 0, 3,       S_TR,   O_TR);
    add("turn_r_retry2",  1, 0, 1, 1, 0, 0, 1,       S_TR,   O_TR);
    add("turn_r_a3_end",  1, 0, 1, 1, 0, 0, 3,       S_TR,   O_TR);
    add("turn_r_fault",   1, 0, 1, 1, 0, 0, 1,       S_STBY, O_FLT);
    add("fault_sticky",   1, 0, 0, 1, 0, 0, D,       S_STBY, O_FLT);
    add("restart_clear",  1, 1, 0, 1, 0, 0, 1,       S_SEEK, O_FWD);
    add("seek_follow",    1, 0, 0, 1, 0, 0, 1,       S_FOL,  O_FWD);
    add("lost_lat_pre",   1, 0, 0, 0, 0, 0, D,       S_FOL,  O_FWD);
    add("lost_count4",    1, 0, 0, 0, 0, 0, 4,       S_FOL,  O_FWD);
    add("turn_l_enter",   1, 0, 0, 0, 0, 0, 1,       S_TL,   O_TL);
    add("turn_l_hold",    1, 0, 0, 1, 0, 0, 3,       S_TL,   O_TL);
    add("turn_l_follow",  1, 0, 0, 1, 0, 0, 1,       S_FOL,  O_FWD);
    add("lost2_count",    1, 0, 0, 0, 0, 0, D + 4,   S_FOL,  O_FWD);
    add("turn_l2_enter",  1, 0, 0, 0, 0, 0, 1,       S_TL,   O_TL);
    add("turn_l2_seek",   1, 0, 0, 0, 0, 0, 4,       S_SEEK, O_FWD);
    add("barr_lat_pre",   1, 0, 0, 0, 0, 1, D,       S_SEEK, O_FWD);
    add("remove_enter",   1, 0, 0, 0, 0, 1, 1,       S_REM,  O_REM);
    add("remove_hold3",   1, 0, 0, 0, 0, 1, 3,       S_REM,  O_REM);
    add("barr_drop_pre",  1, 0, 0, 0, 0, 0, D,       S_REM,  O_REM);
    add("remove_follow",  1, 0, 0, 0, 0, 0, 1,       S_FOL,  O_FWD);
    add("barr2_lat_pre",  1, 0, 0, 0, 0, 1, D,       S_FOL,  O_FWD);
    add("remove2_enter",  1, 0, 0, 0, 0, 1, 1,       S_REM,  O_REM);
    add("remove2_hold7",  1, 0, 0, 0, 0, 1, 7,       S_REM,  O_REM);
    add("remove_timeout", 1, 0, 0, 0, 0, 1, 1,       S_STBY, O_FLT);
    add("clear_barr",     1, 0, 0, 0, 0, 0, D,       S_STBY, O_FLT);
    add("restart2",       1, 1, 0, 0, 0, 0, 1,       S_SEEK, O_FWD);
    add("turn_r2_enter",  1, 0, 1, 0, 0, 0, D + 1,   S_TR,   O_TR);
    add("turn_r2_t1",     1, 0, 1, 0, 0, 0, 1,       S_TR,   O_TR);
    add("under_lat_pre",  1, 0, 1, 0, 1, 0, D,       S_TR,   O_TR);
    add("under_abort",    1, 0, 1, 0, 1, 0, 1,       S_STBY, O_FLT);
    add("start_blk_u",    1, 1, 0, 0, 0, 0, D,       S_STBY, O_FLT);
    add("start_after_u",  1, 1, 0, 0, 0, 0, 1,       S_SEEK, O_FWD);
    add("remove3_enter",  1, 0, 0, 0, 0, 1, D + 1,   S_REM,  O_REM);
    add("reset_in_rem",   0, 0, 0, 0, 0, 0, 1,       S_STBY, O_NONE);
    add("seek_again",     1, 1, 0, 0, 0, 0, 1,       S_SEEK, O_FWD);
    add("under_seek",     1, 0, 0, 0, 1, 0, D + 1,   S_STBY, O_FLT);
    add("reset_clr_flt",  0, 0, 0, 0, 1, 0, 1,       S_STBY, O_NONE);
    add("under_settle",   1, 0, 0, 0, 1, 0, D,       S_STBY, O_NONE);
    add("start_ign_u",    1, 1, 0, 0, 1, 0, 2,       S_STBY, O_NONE);

    reset = 1'b0; start = 1'b0; head = 1'b0; left = 1'b0; under = 1'b0; barreira = 1'b0;
    @(negedge clockc2);
    mon_en = 1'b1;

    foreach (vecs[i]) begin
      reset = vecs[i].rst; start = vecs[i].st; head = vecs[i].hd;
      left = vecs[i].lf; under = vecs[i].un; barreira = vecs[i].ba;
      tick(vecs[i].edges);
      check(vecs[i].name, vecs[i].exp_state, vecs[i].exp_outs);
    end

    // Short head pulse from SEEK: filtered away with debounce, taken as a turn without.
    reset = 1'b0; start = 1'b0; head = 1'b0; left = 1'b0; under = 1'b0; barreira = 1'b0;
    tick(2);
    reset = 1'b1; start = 1'b1;
    tick(1);
    check("glitch_seek", S_SEEK, O_FWD);
    start = 1'b0;
`ifdef WFC_DEBOUNCE_EN
    head = 1'b1;
    tick(2);
    head = 1'b0;
    tick(4);
    check("glitch_ignored", S_SEEK, O_FWD);
`else
    head = 1'b1;
    tick(1);
    head = 1'b0;
    tick(1);
    check("pulse_turn", S_TR, O_TR);
`endif

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wall_follow_ctrl.md
Name: wall_follow_ctrl

Overview:
- Parametrised wall-following controller for the pipe-cleaning robot; next generation of the sensor FSM.
- Adds input debouncing, timed turns in both directions, and a lost-wall timeout.
- Adds a bounded debris-removal phase and a sticky fault indication.
- Sits between raw sensor inputs (head, left, under, barreira) and the motor/brush drivers; outputs are registered Moore outputs.

Parameters:
DEBOUNCE_CYCLES, 3, consecutive stable cycles before a filtered sensor changes (>=1)
TURN_CYCLES, 4, cycles girar is held per turn attempt (>=1)
LOST_CYCLES, 5, consecutive cycles with left=0 in FOLLOW before a left turn (>=1)
REMOVE_MAX, 8, max cycles in REMOVE before fault (>=1)
MAX_TURNS, 3, consecutive right-turn attempts with head still blocked before fault (>=1)

Ports:
clockc2  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  leave STANDBY (level)
head  in  1  front obstacle sensor, raw
left  in  1  left wall sensor, raw
under  in  1  underside/hazard sensor, raw
barreira  in  1  debris barrier sensor, raw
avancar  out  1  drive forward
girar  out  1  rotate
sentido  out  1  rotation direction: 0 = right, 1 = left; valid when girar=1, else 0
remover  out  1  debris brush on
fault  out  1  sticky fault flag
state_o  out  3  current state code

Behaviour:
- Reset (reset=0 at an edge):
  - State becomes STANDBY; all outputs 0; all counters 0.
  - Filtered sensors become 0.
- Debounce:
  - Each sensor has a saturating counter.
  - The filtered bit takes the raw value after DEBOUNCE_CYCLES consecutive edges where raw differs from filtered.
  - Any agreeing cycle clears the counter.
- Timing:
  - The FSM uses filtered bits h, l, u, b.
  - State and outputs update on the same edge; outputs are decoded from next state.
  - Latency from a raw change to the output change is DEBOUNCE_CYCLES+1 edges.
- Priority in every non-STANDBY state: u=1 > b=1 > h=1 > l.
- State codes: STANDBY=0, SEEK=1, FOLLOW=2, TURN_R=3, TURN_L=4, REMOVE=5.
- STANDBY:
  - Outputs 0.
  - start=1 and u=0 -> SEEK; this also clears fault.
- SEEK:
  - avancar=1.
  - u -> STANDBY with fault=1; b -> REMOVE; h -> TURN_R; l -> FOLLOW.
- FOLLOW:
  - avancar=1.
  - u -> STANDBY with fault=1; b -> REMOVE; h -> TURN_R.
  - l=0 increments the lost counter; l=1 clears it.
  - Lost counter reaching LOST_CYCLES -> TURN_L.
- TURN_R:
  - girar=1, sentido=0; turn timer loaded with TURN_CYCLES on entry.
  - When the timer expires: h=0 -> FOLLOW and the retry count clears.
  - If h=1 at expiry: retry count increments and the timer reloads.
  - Retry count reaching MAX_TURNS -> STANDBY with fault=1.
- TURN_L:
  - girar=1, sentido=1 for TURN_CYCLES.
  - At expiry: l=1 -> FOLLOW, else SEEK.
- REMOVE:
  - remover=1, avancar=0.
  - b=0 -> FOLLOW.
  - REMOVE_MAX cycles elapsed with b=1 -> STANDBY with fault=1.
- u=1 in any turn or REMOVE state aborts immediately to STANDBY with fault=1.
- start is ignored outside STANDBY.
- Reset mid-operation overrides everything, including the fault flag.
- Counters are sized $clog2(max+1) and never wrap; they saturate or are reloaded.
- Outputs are one-hot among avancar/girar/remover; at most one is 1.

Optional Feature:
- Macro: WFC_DEBOUNCE_EN.
- Defined: debounce filtering as described.
- Undefined: each filtered bit is the raw input registered by one flop (DEBOUNCE_CYCLES ignored); latency is 2 edges.

Decomposition:
- Package wfc_pkg holds:
  - state enum/localparams (the 3-bit codes above)
  - direction constants SENT_RIGHT=0, SENT_LEFT=1
- Sub-module sensor_debounce (parameter CYCLES, ports clockc2/reset/raw/filt):
  - Instantiated 4x under WFC_DEBOUNCE_EN.

Test Plan:
- Reset, then start=1, all sensors 0 -> SEEK (state_o=1) and avancar=1 within 1 edge; a 2-cycle glitch on head produces no change (debounce=3).
- Hold head=1 in FOLLOW -> TURN_R after 4 edges (girar=1, sentido=0) for 4 cycles; head still 1 -> 3 attempts then STANDBY, fault=1.
- FOLLOW with left dropped to 0 -> after debounce plus 5 cycles, TURN_L (sentido=1) for 4 cycles; left=1 at expiry -> FOLLOW, else SEEK.
- barreira=1 in SEEK -> REMOVE (remover=1); barreira=0 after 4 cycles -> FOLLOW, fault=0; held for 8 cycles -> STANDBY, fault=1.
- under=1 during TURN_R mid-timer -> STANDBY next edge after debounce, fault=1; start=1 with under=0 -> SEEK and fault clears.
- reset=0 while in REMOVE -> next edge: state_o=0, all outputs 0, fault=0; check the same scenarios with WFC_DEBOUNCE_EN undefined (2-edge latency).
